mem_boot_loader: RTL and testbench

- Initiator on the data-memory write interface (addr / wr_data / mem_wr / mem_rd / mask).
- Receives a framed byte stream over a valid/ready link and assembles little-endian 32-bit words.
- Writes each word into memory at consecutive word addresses, holding the core until the image is loaded.
- Sits beside the core's load/store path; the top-level muxes its memory outputs in while core_hold=1.

---
 rtl/mem_boot_loader.sv | 199 +++++++++++++++++++
 tb/tb_mem_boot_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it as little-endian
// words into data memory, holding the core. Optional trailing XOR checksum: MEM_BOOT_LOADER_CHECKSUM_EN.
module mem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic [2:0]  mem_mask,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    , S_CHK = 3'd7
`endif
  } state_t;

  localparam logic [16:0] MAX_C = 17'(MAX_WORDS);

  // Handshake: a byte moves on a rising edge only when rx_valid and rx_ready are both 1;
  // rx_ready depends on state alone, so it never combinationally follows rx_valid.
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] ww_q, ww_d;
  logic        hold_q, hold_d;
  logic [15:0] len_full;
  logic [15:0] ww_inc;
  logic        xfer;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      ww_q    <= 16'd0;
      hold_q  <= 1'b1;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
      csum_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ww_q    <= ww_d;
      hold_q  <= hold_d;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    word_d   = word_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ww_d     = ww_q;
    hold_d   = hold_q;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    rx_ready = 1'b0;
    len_full = {rx_data, len_q[7:0]};
    ww_inc   = ww_q + 16'd1;

    case (state_q)
      S_LEN0, S_LEN1, S_DATA: rx_ready = 1'b1;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
      S_CHK:                  rx_ready = 1'b1;
`endif
      default:                rx_ready = 1'b0;
    endcase
    xfer = rx_valid && rx_ready;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          ww_d    = 16'd0;
          hold_d  = 1'b1;
          state_d = S_LEN0;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          idx_d       = 2'd0;
          if (len_full == 16'd0) begin
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_full} > MAX_C) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          // Address and data are captured on the 4th byte so they are stable for the whole WRITE cycle.
          if (idx_q == 2'd3) begin
            addr_d  = BASE_ADDR + {14'd0, ww_q, 2'b00};
            wdata_d = word_d;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        ww_d = ww_inc;
        if (ww_inc == len_q) begin
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE: begin
        hold_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr      = addr_q;
  assign mem_wr_data   = wdata_q;
  assign mem_wr        = (state_q == S_WRITE);
  assign mem_rd        = 1'b0;
  assign mem_mask      = 3'b010;
  assign core_hold     = hold_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERR);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign words_written = ww_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: frames built from a word-level model, writes checked
// against an expected queue every cycle, plus directed boundary frames.
module tb_mem_boot_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [2:0]  mem_mask;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_addr;
  logic [31:0] last_data;

  mem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_mask(mem_mask), .core_hold(core_hold), .busy(busy), .done(done),
    .err(err), .words_written(words_written), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every cycle
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      last_addr = BASE;
      last_data = 32'd0;
    end else begin
      check("mem_rd", mem_rd, 0);
      check("mem_mask", mem_mask, 3'b010);
      check("busy_and_err", busy && err, 0);
      if (mem_wr) begin
        check("wr_rx_ready", rx_ready, 0);
        check("wr_core_hold", core_hold, 1);
        check("wr_busy", busy, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_wr", mem_wr, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e[63:32]);
          check("wr_data", mem_wr_data, e[31:0]);
        end
        last_addr = mem_addr;
        last_data = mem_wr_data;
      end else begin
        check("addr_hold", mem_addr, last_addr);
        check("data_hold", mem_wr_data, last_data);
      end
    end
  end

  // model: word i is bytes 4i..4i+3 little-endian, at BASE + 4i
  task automatic model_push(input int n, input logic [7:0] data[$]);
    for (int i = 0; i < n; i++)
      exp_q.push_back({BASE + 32'(4 * i),
                       data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]});
  endtask

  // driver: gap<0 gives one idle cycle before every byte, else gap is idle percentage
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap < 0) begin
      rx_valid = 1'b0; rx_data = 8'($urandom);
      @(posedge clk); #1;
    end else begin
      while (int'($urandom_range(99)) < gap) begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1; rx_data = b; t = 0;
    while (!rx_ready && t < 40) begin
      @(posedge clk); #1; t++;
    end
    if (!rx_ready) check("byte_accept_timeout", rx_ready, 1);
    else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_hold", core_hold, 1);
    check("start_err", err, 0);
    check("start_ww", words_written, 0);
  endtask

  // Sends a whole frame (expectations already queued) and checks the outcome.
  task automatic run_frame(input int n, input logic [7:0] data[$], input int gap,
                           input bit bad, input string tag);
    bit over;
    bit exp_done;
    int exp_lat;
    int lat;
    logic [7:0] cs;
    over = (n > MAXW);
    cs = 8'd0;
    do_start();
    send_byte(8'(n), gap);
    send_byte(8'(n >> 8), gap);
    exp_done = !over;
    exp_lat = (!over && n > 0) ? 1 : 0;
    if (!over) begin
      for (int i = 0; i < 4 * n; i++) begin
        send_byte(data[i], gap);
        cs ^= data[i];
      end
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
      send_byte(bad ? (cs ^ 8'h01) : cs, gap);
      exp_done = !bad;
      exp_lat = 0;
`endif
    end
    lat = 0;
    @(negedge clk);
    while (!(done || err) && lat < 20) begin
      @(negedge clk); lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, !exp_done);
    check({tag, "_ww"}, words_written, over ? 0 : n);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    if (exp_done) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_hold_fall"}, core_hold, 0);
      check({tag, "_idle_busy"}, busy, 0);
    end else begin
      check({tag, "_err_hold"}, core_hold, 1);
      check({tag, "_err_busy"}, busy, 0);
      @(negedge clk);
      check({tag, "_err_sticky"}, err, 1);
      check({tag, "_err_rdy"}, rx_ready, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d[$];
    int n;
    bit bad;
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_data", mem_wr_data, 0);
    check("rst_hold", core_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ww", words_written, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_hold", core_hold, 1);
    check("post_rst_busy", busy, 0);

    // basic load with literal expectations
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    exp_q.push_back({32'h0000_0004, 32'h1234_5678});
    run_frame(2, d, 0, 1'b0, "basic");

    // zero length
    d = {};
    run_frame(0, d, 0, 1'b0, "zero");

    // over-length, then recovery from ERR with a valid 1-word frame
    run_frame(257, d, 0, 1'b0, "over");
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_q.push_back({32'h0000_0000, 32'h0403_0201});
    run_frame(1, d, 0, 1'b0, "recover");

    // rx_valid toggling
    d = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    exp_q.push_back({32'h0000_0000, 32'h3CC3_5AA5});
    run_frame(1, d, -1, 1'b0, "toggle");

    // reset mid-word: no write may appear for the aborted frame
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h99, 0);
    send_byte(8'h88, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_rx_ready", rx_ready, 0);
    check("mid_rst_mem_wr", mem_wr, 0);
    check("mid_rst_addr", mem_addr, BASE);
    check("mid_rst_data", mem_wr_data, 0);
    check("mid_rst_hold", core_hold, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ww", words_written, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    d = '{8'h10, 8'h20, 8'h30, 8'h40};
    exp_q.push_back({32'h0000_0000, 32'h4030_2010});
    run_frame(1, d, 0, 1'b0, "after_rst");

`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({32'h0000_0000, 32'h4433_2211});
    run_frame(1, d, 0, 1'b0, "csum_ok");
    exp_q.push_back({32'h0000_0000, 32'h4433_2211});
    run_frame(1, d, 0, 1'b1, "csum_bad");
`endif

    // largest accepted frame
    d = {};
    for (int i = 0; i < 4 * MAXW; i++) d.push_back(8'($urandom));
    model_push(MAXW, d);
    run_frame(MAXW, d, 0, 1'b0, "max_len");

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 6);
      bad = 1'b0;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0);
`endif
      d = {};
      for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
      model_push(n, d);
      run_frame(n, d, int'($urandom_range(0, 50)), bad, "rand");
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
